prime_scan_collector: RTL and testbench



---
 rtl/prime_scan_pkg.sv | 25 ++
 rtl/prime_fifo.sv | 57 +++++
 rtl/prime_scan_collector.sv | 113 +++++++++++
 tb/tb_prime_scan_collector.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/prime_scan_pkg.sv
// rtl/prime_scan_pkg.sv - shared state encoding, defaults and helpers for prime_scan_collector
package prime_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_FIFO_DEPTH = 8;

    // Smallest r such that 2**r >= n; used for FIFO pointer width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prime_fifo.sv
// rtl/prime_fifo.sv - circular-buffer FIFO with registered occupancy, head data always visible
module prime_fifo
    import prime_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic                        full,
    output logic [clog2(DEPTH):0]       count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if the head is popped this cycle.
    assign full     = (count == CNT_W'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prime_scan_collector.sv
// rtl/prime_scan_collector.sv - sweeps [lo, hi] through an external prime checker and queues the primes
module prime_scan_collector
    import prime_scan_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prime_count,
    output logic [WIDTH-1:0] chk_num,
    input  logic             chk_is_prime,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             fifo_full
);

    state_t                     state_q, state_d;
    logic [WIDTH-1:0]           cur;
    logic [WIDTH-1:0]           hi_q;
    logic [WIDTH-1:0]           chk_num_q;
    logic                       load;
    logic                       advance;
    logic                       push;
    logic [clog2(FIFO_DEPTH):0] fifo_count;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign chk_num   = (state_q == SCAN) ? cur : chk_num_q;
    assign out_valid = (fifo_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (lo <= hi) ? SCAN : FIN;
                end
            end
            SCAN: begin
                // A prime with nowhere to go stalls the sweep on the same candidate.
                if (!(chk_is_prime && fifo_full)) begin
                    advance = 1'b1;
                    push    = chk_is_prime;
                    if (cur == hi_q) begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // End of sweep is an equality test, so cur never increments past hi_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= '0;
            hi_q        <= '0;
            prime_count <= '0;
            chk_num_q   <= '0;
        end else begin
            if (load) begin
                cur         <= lo;
                hi_q        <= hi;
                prime_count <= '0;
            end else begin
                if (advance && (cur != hi_q)) begin
                    cur <= cur + 1'b1;
                end
                if (push && (prime_count != '1)) begin
                    prime_count <= prime_count + 1'b1;
                end
            end
            if (state_q == SCAN) begin
                chk_num_q <= cur;
            end
        end
    end

    prime_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (cur),
        .pop       (out_valid && out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_prime_scan_collector.sv
// tb/tb_prime_scan_collector.sv - directed self-checking bench for prime_scan_collector
module tb_prime_scan_collector;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       busy;
    logic       done;
    logic [7:0] prime_count;
    logic [7:0] chk_num;
    logic       chk_is_prime;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       fifo_full;

    int tests;
    int fails;
    int done_cnt;
    int zero_seen;
    int cyc;
    int got[$];

    int exp_a[] = '{2, 3, 5, 7, 11, 13, 17, 19};
    int exp_b[] = '{241, 251};
    int exp_c[] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59};
    int exp_d[] = '{97};
    int exp_e[] = '{2, 3, 5, 7};

    prime_scan_collector #(.WIDTH(8), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .lo           (lo),
        .hi           (hi),
        .busy         (busy),
        .done         (done),
        .prime_count  (prime_count),
        .chk_num      (chk_num),
        .chk_is_prime (chk_is_prime),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_full    (fifo_full)
    );

    function automatic logic is_prime_f(input logic [7:0] n);
        int v;
        v = int'(n);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) begin
            if (v % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    assign chk_is_prime = is_prime_f(chk_num);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back(int'(out_data));
        if (rst_n && done) done_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_list(input string tag, input int exp[]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
        end
    endtask

    task automatic start_sweep(input int l, input int h);
        @(negedge clk);
        start = 1'b1;
        lo    = 8'(l);
        hi    = 8'(h);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int first, output int c);
        c = first;
        while (!done && c < 500) begin
            if (busy && chk_num == 8'd0) zero_seen++;
            @(negedge clk);
            c++;
        end
        check("done_within_bound", int'(done), 1);
    endtask

    initial begin
        tests = 0; fails = 0; done_cnt = 0; zero_seen = 0;
        rst_n = 1'b0; start = 1'b0; lo = '0; hi = '0; out_ready = 1'b0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_fifo_full", int'(fifo_full), 0);
        check("rst_prime_count", int'(prime_count), 0);
        check("rst_chk_num", int'(chk_num), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: 2..20, drained continuously
        got.delete(); done_cnt = 0; out_ready = 1'b1;
        start_sweep(2, 20);
        check("s1_first_chk", int'(chk_num), 2);
        check("s1_busy", int'(busy), 1);
        wait_done(1, cyc);
        check("s1_done_latency", cyc, 20);
        repeat (6) @(negedge clk);
        check_list("s1_out", exp_a);
        check("s1_prime_count", int'(prime_count), 8);
        check("s1_done_pulses", done_cnt, 1);
        check("s1_idle", int'(busy), 0);

        // Scenario 2: top of range, no wrap
        got.delete(); done_cnt = 0; zero_seen = 0;
        start_sweep(240, 255);
        wait_done(1, cyc);
        check("s2_done_latency", cyc, 17);
        repeat (4) @(negedge clk);
        check_list("s2_out", exp_b);
        check("s2_prime_count", int'(prime_count), 2);
        check("s2_no_wrap", zero_seen, 0);
        check("s2_done_pulses", done_cnt, 1);

        // Scenario 3: backpressure fills the FIFO, then release
        got.delete(); done_cnt = 0; out_ready = 1'b0;
        start_sweep(2, 60);
        repeat (30) @(negedge clk);
        check("s3_full", int'(fifo_full), 1);
        check("s3_stall_chk", int'(chk_num), 23);
        check("s3_stall_busy", int'(busy), 1);
        check("s3_head", int'(out_data), 2);
        check("s3_count_at_stall", int'(prime_count), 8);
        check("s3_no_done_yet", done_cnt, 0);
        out_ready = 1'b1;
        wait_done(0, cyc);
        repeat (12) @(negedge clk);
        check_list("s3_out", exp_c);
        check("s3_prime_count", int'(prime_count), 17);
        check("s3_drained", int'(out_valid), 0);

        // Scenario 4: empty range, then single-element range
        got.delete(); done_cnt = 0;
        start_sweep(30, 10);
        check("s4_done_n1", int'(done), 1);
        check("s4_busy_fin", int'(busy), 1);
        check("s4_chk_hold", int'(chk_num), 60);
        @(negedge clk);
        check("s4_done_one_cycle", int'(done), 0);
        check("s4_idle", int'(busy), 0);
        check("s4_prime_count", int'(prime_count), 0);
        check("s4_out_valid", int'(out_valid), 0);
        check("s4_done_pulses", done_cnt, 1);
        start_sweep(97, 97);
        wait_done(1, cyc);
        check("s4b_done_latency", cyc, 2);
        repeat (3) @(negedge clk);
        check_list("s4b_out", exp_d);
        check("s4b_prime_count", int'(prime_count), 1);

        // Scenario 5: start ignored while busy, then reset mid-sweep
        got.delete(); done_cnt = 0;
        start_sweep(2, 20);
        start = 1'b1; lo = 8'd100; hi = 8'd200;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(4, cyc);
        check("s5_done_latency", cyc, 20);
        repeat (6) @(negedge clk);
        check_list("s5_out", exp_a);
        check("s5_prime_count", int'(prime_count), 8);
        check("s5_done_pulses", done_cnt, 1);

        got.delete(); out_ready = 1'b0;
        start_sweep(2, 100);
        repeat (10) @(negedge clk);
        check("s5_pre_rst_valid", int'(out_valid), 1);
        check("s5_pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_valid", int'(out_valid), 0);
        check("s5_rst_data", int'(out_data), 0);
        check("s5_rst_busy", int'(busy), 0);
        check("s5_rst_count", int'(prime_count), 0);
        check("s5_rst_chk", int'(chk_num), 0);
        check("s5_rst_full", int'(fifo_full), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got.delete(); done_cnt = 0; out_ready = 1'b1;
        start_sweep(2, 10);
        wait_done(1, cyc);
        check("s5b_done_latency", cyc, 10);
        repeat (5) @(negedge clk);
        check_list("s5b_out", exp_e);
        check("s5b_prime_count", int'(prime_count), 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
